// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// rv_ctrl_pkg : shared encodings for the multicycle RV32I control path
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_opimm  = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;

  localparam logic [2:0] c_imm_u = 3'b000;
  localparam logic [2:0] c_imm_i = 3'b001;
  localparam logic [2:0] c_imm_s = 3'b010;
  localparam logic [2:0] c_imm_b = 3'b011;
  localparam logic [2:0] c_imm_j = 3'b100;

  localparam logic [1:0] c_alu_add   = 2'b00;
  localparam logic [1:0] c_alu_cmp   = 2'b01;
  localparam logic [1:0] c_alu_funct = 2'b10;

  localparam logic [1:0] c_wb_alu = 2'b00;
  localparam logic [1:0] c_wb_mem = 2'b01;
  localparam logic [1:0] c_wb_pc4 = 2'b10;
  localparam logic [1:0] c_wb_imm = 2'b11;

  localparam logic [1:0] c_cause_none    = 2'b00;
  localparam logic [1:0] c_cause_illegal = 2'b01;
  localparam logic [1:0] c_cause_timeout = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH,
    CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_ILLEGAL
  } class_e;

  function automatic class_e decode_class(input logic [6:0] opc);
    case (opc)
      c_opc_lui:    return CL_LUI;
      c_opc_auipc:  return CL_AUIPC;
      c_opc_jal:    return CL_JAL;
      c_opc_jalr:   return CL_JALR;
      c_opc_branch: return CL_BRANCH;
      c_opc_load:   return CL_LOAD;
      c_opc_store:  return CL_STORE;
      c_opc_opimm:  return CL_OPIMM;
      c_opc_op:     return CL_OP;
      default:      return CL_ILLEGAL;
    endcase
  endfunction

  function automatic logic [2:0] imm_sel_of(input class_e cls);
    case (cls)
      CL_LUI, CL_AUIPC: return c_imm_u;
      CL_STORE:         return c_imm_s;
      CL_BRANCH:        return c_imm_b;
      CL_JAL:           return c_imm_j;
      default:          return c_imm_i;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_multicycle_controller_timeout.sv
// ============================================================================
// rv_mem_timeout : counts cycles a memory request waits, flags expiry
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_mem_timeout #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  output logic expire_o
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = ^{clk, rst, wait_i};
      assign expire_o = 1'b0;
    end else begin : g_enabled
      localparam int c_cw = $clog2(MEM_TIMEOUT + 1);
      logic [c_cw-1:0] count_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q <= '0;
        end else if (!wait_i) begin
          count_q <= '0;
        end else if (count_q != c_cw'(MEM_TIMEOUT)) begin
          count_q <= count_q + 1'b1;
        end
      end

      // Fires on the MEM_TIMEOUT-th consecutive waiting cycle; a ready in that cycle wins.
      assign expire_o = wait_i && (count_q == c_cw'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rv_multicycle_controller.sv
// ============================================================================
// rv_multicycle_controller : fetch/decode/execute/memory/writeback control FSM
// Optional perf counters enabled by macro CTRL_PERF_COUNTERS_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 64,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_register,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic [2:0]  immediate_select,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_select,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);

  state_e      state_q;
  class_e      class_q;
  class_e      class_d;
  logic        mem_req_q, mem_we_q, mem_addr_sel_q;
  logic [2:0]  imm_sel_q;
  logic        alu_src_a_q, alu_src_b_q;
  logic [1:0]  alu_op_q;
  logic        pc_write_q, pc_src_q, reg_write_q;
  logic [1:0]  wb_select_q;
  logic        trap_q;
  logic [1:0]  trap_cause_q;
  logic        w_accept, w_expire, w_rd_nz;
  logic        w_unused_ir;

  assign class_d     = decode_class(instruction_register[6:0]);
  assign w_rd_nz     = (instruction_register[11:7] != 5'd0);
  assign w_accept    = mem_req_q & mem_ready;
  assign w_unused_ir = ^instruction_register[31:12];

  rv_mem_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .wait_i   (mem_req_q & ~mem_ready),
    .expire_o (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RESET_HALTED ? ST_HALT : ST_FETCH;
      class_q        <= CL_ILLEGAL;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_sel_q <= 1'b0;
      imm_sel_q      <= c_imm_u;
      alu_src_a_q    <= 1'b0;
      alu_src_b_q    <= 1'b0;
      alu_op_q       <= c_alu_add;
      pc_write_q     <= 1'b0;
      pc_src_q       <= 1'b0;
      reg_write_q    <= 1'b0;
      wb_select_q    <= c_wb_alu;
      trap_q         <= 1'b0;
      trap_cause_q   <= c_cause_none;
    end else begin
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          // Outputs come out of reset low, so the first fetch raises the request a cycle late.
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mem_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_DECODE;
          end else if (w_expire) begin
            mem_req_q    <= 1'b0;
            trap_q       <= 1'b1;
            trap_cause_q <= c_cause_timeout;
            state_q      <= ST_TRAP;
          end
        end
        ST_DECODE: begin
          class_q <= class_d;
          if (class_d == CL_ILLEGAL) begin
            trap_q       <= 1'b1;
            trap_cause_q <= c_cause_illegal;
            state_q      <= ST_TRAP;
          end else begin
            imm_sel_q   <= imm_sel_of(class_d);
            alu_src_a_q <= class_d inside {CL_AUIPC, CL_JAL};
            alu_src_b_q <= !(class_d inside {CL_BRANCH, CL_OP});
            alu_op_q    <= (class_d == CL_BRANCH) ? c_alu_cmp :
                           (class_d inside {CL_OPIMM, CL_OP}) ? c_alu_funct : c_alu_add;
            pc_write_q  <= class_d inside {CL_BRANCH, CL_JAL, CL_JALR};
            pc_src_q    <= class_d inside {CL_JAL, CL_JALR};
            state_q     <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          pc_src_q <= 1'b0;
          case (class_q)
            CL_BRANCH: begin
              alu_src_a_q <= 1'b0;
              alu_src_b_q <= 1'b0;
              alu_op_q    <= c_alu_add;
              mem_req_q   <= 1'b1;
              state_q     <= ST_FETCH;
            end
            CL_LOAD, CL_STORE: begin
              mem_req_q      <= 1'b1;
              mem_addr_sel_q <= 1'b1;
              mem_we_q       <= (class_q == CL_STORE);
              state_q        <= ST_MEMORY;
            end
            default: begin
              alu_src_a_q <= 1'b0;
              alu_src_b_q <= 1'b0;
              alu_op_q    <= c_alu_add;
              reg_write_q <= w_rd_nz;
              pc_write_q  <= !(class_q inside {CL_JAL, CL_JALR});
              wb_select_q <= (class_q inside {CL_JAL, CL_JALR}) ? c_wb_pc4 :
                             (class_q == CL_LUI) ? c_wb_imm : c_wb_alu;
              state_q     <= ST_WRITEBACK;
            end
          endcase
        end
        ST_MEMORY: begin
          if (mem_ready || w_expire) begin
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_sel_q <= 1'b0;
            alu_src_a_q    <= 1'b0;
            alu_src_b_q    <= 1'b0;
            alu_op_q       <= c_alu_add;
          end
          if (mem_ready) begin
            if (class_q == CL_STORE) begin
              mem_req_q <= 1'b1;
              state_q   <= ST_FETCH;
            end else begin
              reg_write_q <= w_rd_nz;
              pc_write_q  <= 1'b1;
              wb_select_q <= c_wb_mem;
              state_q     <= ST_WRITEBACK;
            end
          end else if (w_expire) begin
            trap_q       <= 1'b1;
            trap_cause_q <= c_cause_timeout;
            state_q      <= ST_TRAP;
          end
        end
        ST_WRITEBACK: begin
          wb_select_q <= c_wb_alu;
          mem_req_q   <= 1'b1;
          state_q     <= ST_FETCH;
        end
        ST_TRAP, ST_HALT: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign mem_addr_sel     = mem_addr_sel_q;
  assign ir_write         = (state_q == ST_FETCH) & w_accept;
  assign immediate_select = imm_sel_q;
  assign alu_src_a        = alu_src_a_q;
  assign alu_src_b        = alu_src_b_q;
  assign alu_op           = alu_op_q;
  // Store retires its PC update in the cycle memory accepts it.
  assign pc_write         = pc_write_q |
                            ((state_q == ST_MEMORY) & (class_q == CL_STORE) & w_accept);
  assign pc_src           = ((state_q == ST_EXECUTE) && (class_q == CL_BRANCH)) ?
                            branch_taken : pc_src_q;
  assign reg_write        = reg_write_q;
  assign wb_select        = wb_select_q;
  assign trap             = trap_q;
  assign trap_cause       = trap_cause_q;

`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count_q, instret_count_q;
  logic        w_retire, w_frozen;

  assign w_frozen = (state_q == ST_TRAP) || (state_q == ST_HALT);
  assign w_retire = ((state_q == ST_EXECUTE) && (class_q == CL_BRANCH)) ||
                    ((state_q == ST_MEMORY) && (class_q == CL_STORE) && w_accept) ||
                    (state_q == ST_WRITEBACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count_q   <= '0;
      instret_count_q <= '0;
    end else if (!w_frozen) begin
      cycle_count_q <= cycle_count_q + 32'd1;
      if (w_retire) begin
        instret_count_q <= instret_count_q + 32'd1;
      end
    end
  end

  assign cycle_count   = cycle_count_q;
  assign instret_count = instret_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_multicycle_controller.sv
// ============================================================================
// tb_rv_multicycle_controller : vector table, random instructions, corner cases
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction_register = 32'h0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_write;
  logic [2:0]  immediate_select;
  logic        alu_src_a, alu_src_b;
  logic [1:0]  alu_op;
  logic        pc_write, pc_src, reg_write;
  logic [1:0]  wb_select;
  logic        trap;
  logic [1:0]  trap_cause;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count;
`endif

  rv_multicycle_controller #(
    .MEM_TIMEOUT  (4),
    .RESET_HALTED (1'b0)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .instruction_register (instruction_register),
    .branch_taken         (branch_taken),
    .mem_ready            (mem_ready),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr_sel         (mem_addr_sel),
    .ir_write             (ir_write),
    .immediate_select     (immediate_select),
    .alu_src_a            (alu_src_a),
    .alu_src_b            (alu_src_b),
    .alu_op               (alu_op),
    .pc_write             (pc_write),
    .pc_src               (pc_src),
    .reg_write            (reg_write),
    .wb_select            (wb_select),
    .trap                 (trap),
    .trap_cause           (trap_cause)
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    .cycle_count          (cycle_count),
    .instret_count        (instret_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic        taken;
    int          fd, md;
    int          cycles, memreq, memwe, memaddr;
    logic [2:0]  imm;
    logic        a, b;
    logic [1:0]  op;
    logic        pcsrc;
    int          regw;
    logic        chk_wb;
    logic [1:0]  wb;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: cycle counts from fetch/memory wait states and class.
  function automatic vec_t model(input logic [31:0] ir, input logic taken, input int fd, input int md);
    vec_t v;
    logic [6:0] opc;
    bit is_mem, is_st, has_wb;
    opc = ir[6:0];
    v.ir = ir; v.taken = taken; v.fd = fd; v.md = md;
    v.a = 1'b0; v.b = 1'b1; v.op = 2'd0; v.pcsrc = 1'b0; v.wb = 2'd0; v.imm = 3'd1;
    is_mem = (opc == 7'h03) || (opc == 7'h23);
    is_st  = (opc == 7'h23);
    has_wb = !((opc == 7'h63) || (opc == 7'h23));
    case (opc)
      7'h37: begin v.imm = 3'd0; v.wb = 2'd3; end
      7'h17: begin v.imm = 3'd0; v.a = 1'b1; end
      7'h6F: begin v.imm = 3'd4; v.a = 1'b1; v.pcsrc = 1'b1; v.wb = 2'd2; end
      7'h67: begin v.imm = 3'd1; v.pcsrc = 1'b1; v.wb = 2'd2; end
      7'h63: begin v.imm = 3'd3; v.b = 1'b0; v.op = 2'd1; v.pcsrc = taken; end
      7'h03: begin v.imm = 3'd1; v.wb = 2'd1; end
      7'h23: begin v.imm = 3'd2; end
      7'h13: begin v.imm = 3'd1; v.op = 2'd2; end
      default: begin v.imm = 3'd1; v.b = 1'b0; v.op = 2'd2; end
    endcase
    v.cycles  = (fd + 1) + 2 + (is_mem ? md + 1 : 0) + (has_wb ? 1 : 0);
    v.memreq  = (fd + 1) + (is_mem ? md + 1 : 0);
    v.memwe   = is_st ? md + 1 : 0;
    v.memaddr = is_mem ? md + 1 : 0;
    v.regw    = (has_wb && ir[11:7] != 5'd0) ? 1 : 0;
    v.chk_wb  = has_wb;
    return v;
  endfunction

  // Entered and left #1 after a rising edge with the controller requesting a fetch.
  task automatic run_instr(input string tag, input vec_t v);
    int reqn, dly, n_req, n_we, n_addr, n_irw, n_pcw, n_rw;
    logic got_pcsrc, got_a, got_b;
    logic [2:0] got_imm;
    logic [1:0] got_op, got_wb;
    reqn = 0; dly = v.fd; n_req = 0; n_we = 0; n_addr = 0; n_irw = 0; n_pcw = 0; n_rw = 0;
    got_pcsrc = 1'bx; got_a = 1'bx; got_b = 1'bx; got_imm = 'x; got_op = 'x; got_wb = 'x;
    instruction_register = v.ir;
    branch_taken = v.taken;
    for (int c = 1; c <= v.cycles; c++) begin
      if (mem_req) begin
        mem_ready = (reqn == dly);
        if (reqn == dly) begin reqn = 0; dly = v.md; end
        else reqn++;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (mem_req) n_req++;
      if (mem_req && mem_we) n_we++;
      if (mem_req && mem_addr_sel) n_addr++;
      if (ir_write) n_irw++;
      if (pc_write) begin n_pcw++; got_pcsrc = pc_src; end
      if (reg_write) n_rw++;
      if (c == v.fd + 3) begin
        got_imm = immediate_select; got_a = alu_src_a; got_b = alu_src_b; got_op = alu_op;
      end
      if (c == v.cycles) got_wb = wb_select;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    chk({tag, "_back_in_fetch"}, mem_req, 1);
    chk({tag, "_mem_req_cycles"}, n_req, v.memreq);
    chk({tag, "_mem_we_cycles"}, n_we, v.memwe);
    chk({tag, "_mem_addr_sel_cycles"}, n_addr, v.memaddr);
    chk({tag, "_ir_write_count"}, n_irw, 1);
    chk({tag, "_pc_write_count"}, n_pcw, 1);
    chk({tag, "_pc_src"}, got_pcsrc, v.pcsrc);
    chk({tag, "_imm_sel"}, got_imm, v.imm);
    chk({tag, "_alu_src"}, {got_a, got_b}, {v.a, v.b});
    chk({tag, "_alu_op"}, got_op, v.op);
    chk({tag, "_reg_write_count"}, n_rw, v.regw);
    if (v.chk_wb) chk({tag, "_wb_select"}, got_wb, v.wb);
    chk({tag, "_no_trap"}, {trap, trap_cause}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs_zero",
        {mem_req, mem_we, mem_addr_sel, ir_write, immediate_select, alu_src_a, alu_src_b,
         alu_op, pc_write, pc_src, reg_write, wb_select, trap, trap_cause}, 0);
    @(posedge clk); #1;
    chk("reset_fetch_request", mem_req, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [13];
    logic [6:0] opcs [9];
    logic [31:0] rnd;
    vec_t v;
    int n;

    tbl[0]  = '{32'h00500093, 0, 0, 0,  4, 1, 0, 0, 3'd1, 0, 1, 2'd2, 0, 1, 1, 2'd0};
    tbl[1]  = '{32'h00000463, 1, 0, 0,  3, 1, 0, 0, 3'd3, 0, 0, 2'd1, 1, 0, 0, 2'd0};
    tbl[2]  = '{32'h00000463, 0, 2, 0,  5, 3, 0, 0, 3'd3, 0, 0, 2'd1, 0, 0, 0, 2'd0};
    tbl[3]  = '{32'h0000A103, 0, 0, 3,  8, 5, 0, 4, 3'd1, 0, 1, 2'd0, 0, 1, 1, 2'd1};
    tbl[4]  = '{32'h0020A023, 0, 1, 0,  5, 3, 1, 1, 3'd2, 0, 1, 2'd0, 0, 0, 0, 2'd0};
    tbl[5]  = '{32'h123452B7, 0, 0, 0,  4, 1, 0, 0, 3'd0, 0, 1, 2'd0, 0, 1, 1, 2'd3};
    tbl[6]  = '{32'h00001197, 0, 0, 0,  4, 1, 0, 0, 3'd0, 1, 1, 2'd0, 0, 1, 1, 2'd0};
    tbl[7]  = '{32'h008000EF, 0, 0, 0,  4, 1, 0, 0, 3'd4, 1, 1, 2'd0, 1, 1, 1, 2'd2};
    tbl[8]  = '{32'h00008067, 1, 0, 0,  4, 1, 0, 0, 3'd1, 0, 1, 2'd0, 1, 0, 1, 2'd2};
    tbl[9]  = '{32'h002081B3, 0, 0, 0,  4, 1, 0, 0, 3'd1, 0, 0, 2'd2, 0, 1, 1, 2'd0};
    tbl[10] = '{32'h00000013, 0, 0, 0,  4, 1, 0, 0, 3'd1, 0, 1, 2'd2, 0, 0, 1, 2'd0};
    tbl[11] = '{32'h0000A103, 0, 3, 3, 11, 8, 0, 4, 3'd1, 0, 1, 2'd0, 0, 1, 1, 2'd1};
    tbl[12] = '{32'h0020A023, 0, 3, 3, 10, 8, 4, 4, 3'd2, 0, 1, 2'd0, 0, 0, 0, 2'd0};

    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      run_instr($sformatf("vec%0d", i), tbl[i]);
    end

    for (int i = 0; i < 150; i++) begin
      rnd = $urandom();
      rnd[6:0] = opcs[$urandom_range(0, 8)];
      v = model(rnd, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
      run_instr($sformatf("rnd%0d_ir%08h", i, rnd), v);
    end

    // Illegal opcode: trap after decode, no further requests.
    instruction_register = 32'hFFFFFFFF;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("illegal_trap", trap, 1);
    chk("illegal_cause", trap_cause, 2'b01);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      if (mem_req || pc_write || reg_write) n++;
      @(posedge clk); #1;
    end
    chk("illegal_quiet_after_trap", n, 0);
    chk("illegal_trap_sticky", trap, 1);
    do_reset();

    // Fetch never answered: trap after MEM_TIMEOUT waiting cycles.
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (trap) break;
      if (mem_req) n++;
      @(posedge clk); #1;
    end
    chk("timeout_wait_cycles", n, 4);
    chk("timeout_trap", trap, 1);
    chk("timeout_cause", trap_cause, 2'b10);
    chk("timeout_req_dropped", mem_req, 0);
    @(posedge clk); #1;
    chk("timeout_req_stays_low", mem_req, 0);
    do_reset();

    // Asynchronous reset in the middle of a store's memory phase.
    instruction_register = 32'h0020A023;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("sw_mem_req", mem_req, 1);
    chk("sw_mem_we", mem_we, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_mem_we", mem_we, 0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
